// File: rtl/riscv_pkg.sv
// Shared types for the register-file writeback controller: writeback source select,
// load funct3 encodings and the in-flight slot record.
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_NONE = 2'd3
  } wbsel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwen;
    wbsel_e     wbsel;
    logic [2:0] funct3;
  } wb_slot_t;

endpackage

// File: rtl/riscv_writeback_ctrl_if.sv
// Issue bundle into the writeback controller and its write port towards the regfile.
interface riscv_writeback_ctrl_if #(
  parameter int XLEN = 32
);
  logic            issue_valid_i;
  logic [4:0]      issue_rd_i;
  logic            issue_regwen_i;
  logic [1:0]      issue_wbsel_i;
  logic [2:0]      issue_funct3_i;
  logic [XLEN-1:0] issue_pc4_i;
  logic [4:0]      AddrD_o;
  logic [XLEN-1:0] DataD_o;
  logic            RegWEn_o;

  modport master (
    output issue_valid_i, issue_rd_i, issue_regwen_i, issue_wbsel_i, issue_funct3_i,
           issue_pc4_i,
    input  AddrD_o, DataD_o, RegWEn_o
  );

  modport slave (
    input  issue_valid_i, issue_rd_i, issue_regwen_i, issue_wbsel_i, issue_funct3_i,
           issue_pc4_i,
    output AddrD_o, DataD_o, RegWEn_o
  );
endinterface

// File: rtl/riscv_load_align.sv
// Extracts the addressed byte/half/word from a raw memory word and sign- or zero-extends it.
module riscv_load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{addr_i, 3'b000} +: 8];
    half_sel = word_i[{addr_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   data_o = word_i;
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/riscv_writeback_ctrl.sv
// Regfile write-side driver: rd leaves at issue, data/enable follow three cycles later to
// line up with the regfile's delayed AddrD. Also flags RAW hazards and counts retired writes.
module riscv_writeback_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  riscv_writeback_ctrl_if.slave  wb_if,
  input  logic                   flush_i,
  input  logic [XLEN-1:0]        ex_alu_i,
  input  logic [XLEN-1:0]        mem_rdata_i,
  input  logic [4:0]             rs1_i,
  input  logic [4:0]             rs2_i,
  output logic                   hazard_o,
  output logic [CNT_W-1:0]       retired_cnt_o
);

  wb_slot_t        issue_slot;
  wb_slot_t        slot1_d, slot1_q;
  wb_slot_t        slot2_d, slot2_q;
  logic            slot3_we_d, slot3_we_q;
  logic [XLEN-1:0] pc4_1_q, pc4_2_q, alu_2_q;
  logic [XLEN-1:0] data_3_d, data_3_q;
  logic [XLEN-1:0] load_data;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  function automatic logic hit(input wb_slot_t s, input logic [4:0] rs);
    return s.valid & s.regwen & (rs != 5'd0) & (s.rd == rs);
  endfunction

  // Issue stage (cycle T): a flushed issue is already invalid here.
  always_comb begin
    issue_slot        = '0;
    issue_slot.valid  = wb_if.issue_valid_i & ~flush_i;
    issue_slot.rd     = wb_if.issue_rd_i;
    issue_slot.regwen = wb_if.issue_regwen_i;
    issue_slot.wbsel  = wbsel_e'(wb_if.issue_wbsel_i);
    issue_slot.funct3 = wb_if.issue_funct3_i;
  end

  assign wb_if.AddrD_o = (wb_if.issue_valid_i & wb_if.issue_regwen_i & ~flush_i)
                         ? wb_if.issue_rd_i : 5'd0;

  riscv_load_align #(.XLEN(XLEN)) u_load_align (
    .funct3_i (slot2_q.funct3),
    .addr_i   (alu_2_q[1:0]),
    .word_i   (mem_rdata_i),
    .data_o   (load_data)
  );

  // Slot1 -> slot2 (T+1) and slot2 -> slot3 (T+2); the slot2 entry is never flushed.
  always_comb begin
    slot1_d       = issue_slot;
    slot2_d       = slot1_q;
    slot2_d.valid = slot1_q.valid & ~flush_i;
    slot3_we_d    = slot2_q.valid & slot2_q.regwen & (slot2_q.wbsel != WB_NONE) &
                    (slot2_q.rd != 5'd0);
    case (slot2_q.wbsel)
      WB_ALU:  data_3_d = alu_2_q;
      WB_LOAD: data_3_d = load_data;
      WB_PC4:  data_3_d = pc4_2_q;
      default: data_3_d = '0;
    endcase
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, slot3_we_q};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot1_q.valid <= 1'b0;
      slot2_q.valid <= 1'b0;
      slot3_we_q    <= 1'b0;
      data_3_q      <= '0;
      cnt_q         <= '0;
    end else begin
      slot1_q    <= slot1_d;
      slot2_q    <= slot2_d;
      slot3_we_q <= slot3_we_d;
      data_3_q   <= data_3_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    pc4_1_q <= wb_if.issue_pc4_i;
    pc4_2_q <= pc4_1_q;
    alu_2_q <= ex_alu_i;
  end

  // Slot3 (T+3) drives the regfile; it is left out of the hazard check because the
  // regfile read already sees a write committing this cycle.
  assign wb_if.RegWEn_o = slot3_we_q;
  assign wb_if.DataD_o  = data_3_q;
  assign retired_cnt_o  = cnt_q;
  assign hazard_o = hit(issue_slot, rs1_i) | hit(issue_slot, rs2_i) |
                    hit(slot1_q, rs1_i)    | hit(slot1_q, rs2_i)    |
                    hit(slot2_q, rs1_i)    | hit(slot2_q, rs2_i);

endmodule

// File: tb/tb_riscv_writeback_ctrl.sv
// Bench for riscv_writeback_ctrl: directed vector table followed by a randomized run
// against a per-cycle transaction model.
module tb_riscv_writeback_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 32;
  localparam int NR    = 600;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] ex_alu = '0;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        hazard;
  logic [31:0] cnt;

  riscv_writeback_ctrl_if #(.XLEN(XLEN)) wb_if ();

  riscv_writeback_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wb_if         (wb_if),
    .flush_i       (flush),
    .ex_alu_i      (ex_alu),
    .mem_rdata_i   (mem_rdata),
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .hazard_o      (hazard),
    .retired_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          r, f, iv;
    logic [4:0]  rd;
    logic [1:0]  ws;
    logic [2:0]  f3;
    logic [31:0] pc4, alu, mem;
    logic [4:0]  a, b;
    logic [4:0]  e_addr;
    bit          e_we;
    logic [31:0] e_data;
    bit          e_haz;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, f, iv, input logic [4:0] rd, input logic [1:0] ws,
                     input logic [2:0] f3, input logic [31:0] pc4, alu, mem,
                     input logic [4:0] a, b, input logic [4:0] e_addr, input bit e_we,
                     input logic [31:0] e_data, input bit e_haz, input logic [31:0] e_cnt);
    vec_t v;
    v = '{r, f, iv, rd, ws, f3, pc4, alu, mem, a, b, e_addr, e_we, e_data, e_haz, e_cnt};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, f, iv, rw, input logic [4:0] rd, input logic [1:0] ws,
                       input logic [2:0] f3, input logic [31:0] pc4, alu, mem,
                       input logic [4:0] a, b);
    rst                  = r;
    flush                = f;
    wb_if.issue_valid_i  = iv;
    wb_if.issue_regwen_i = rw;
    wb_if.issue_rd_i     = rd;
    wb_if.issue_wbsel_i  = ws;
    wb_if.issue_funct3_i = f3;
    wb_if.issue_pc4_i    = pc4;
    ex_alu               = alu;
    mem_rdata            = mem;
    rs1                  = a;
    rs2                  = b;
  endtask

  task automatic check_outs(input string tag, input logic [4:0] e_addr, input bit e_we,
                            input logic [31:0] e_data, input bit e_haz,
                            input logic [31:0] e_cnt);
    chk({tag, " AddrD"},  32'(wb_if.AddrD_o), 32'(e_addr));
    chk({tag, " RegWEn"}, 32'(wb_if.RegWEn_o), 32'(e_we));
    if (e_we) chk({tag, " DataD"}, wb_if.DataD_o, e_data);
    chk({tag, " hazard"}, 32'(hazard), 32'(e_haz));
    chk({tag, " count"},  cnt, e_cnt);
  endtask

  // Randomized run records
  bit          r_rst[NR], r_fl[NR], r_iv[NR], r_rw[NR];
  logic [4:0]  r_rd[NR], r_rs1[NR], r_rs2[NR];
  logic [1:0]  r_ws[NR];
  logic [2:0]  r_f3[NR];
  logic [31:0] r_pc4[NR], r_alu[NR], r_mem[NR];

  // Is the instruction issued in cycle t still in flight during cycle c (t < c <= t+3)?
  function automatic bit m_alive(input int t, input int c);
    if (t < 0) return 1'b0;
    if (!r_iv[t]) return 1'b0;
    for (int k = t; k < c; k++) begin
      if (r_rst[k]) return 1'b0;
      if (k <= t + 1 && r_fl[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] w);
    logic [31:0] b8, h16;
    b8  = w >> (8 * off);
    h16 = w >> (16 * off[1]);
    case (f3)
      3'd0:    return 32'($signed(b8[7:0]));
      3'd4:    return 32'(b8[7:0]);
      3'd1:    return 32'($signed(h16[15:0]));
      3'd5:    return 32'(h16[15:0]);
      default: return w;
    endcase
  endfunction

  function automatic bit m_we(input int c);
    int t;
    t = c - 3;
    if (!m_alive(t, c)) return 1'b0;
    return r_rw[t] && r_ws[t] != 2'd3 && r_rd[t] != 5'd0;
  endfunction

  function automatic logic [31:0] m_data(input int c);
    int t;
    t = c - 3;
    case (r_ws[t])
      2'd0:    return r_alu[t+1];
      2'd1:    return m_load(r_f3[t], r_alu[t+1][1:0], r_mem[t+2]);
      2'd2:    return r_pc4[t];
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_pending(input int c, input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    if (r_iv[c] && r_rw[c] && !r_fl[c] && r_rd[c] == rs) return 1'b1;
    for (int d = 1; d <= 2; d++)
      if (m_alive(c - d, c) && r_rw[c-d] && r_rd[c-d] == rs) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    int model_cnt;
    logic [4:0] e_addr;

    // Reset, then check the idle post-reset state with a nonzero read address.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    @(negedge clk);
    check_outs("reset", 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("reset DataD", wb_if.DataD_o, 32'd0);
    @(posedge clk);
    #1;

    //   r f iv rd ws f3     pc4          alu            mem            a   b   addr we data        hz cnt
    add(0,0,1, 5, 0,3'd0, 32'h100,     32'h0,         32'h0,         0,  0,  5, 0,32'h0,        0, 0); // 0
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h1234,      32'h0,         0,  0,  0, 0,32'h0,        0, 0);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 0);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 1,32'h1234,     0, 0);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 1);
    add(0,0,1, 7, 1,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  7, 0,32'h0,        0, 1); // 5 LB
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h1003,      32'h0,         0,  0,  0, 0,32'h0,        0, 1);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h80FF_FF01, 0,  0,  0, 0,32'h0,        0, 1);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 1,32'hFFFF_FF80,0, 1);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 2);
    add(0,0,1, 9, 1,3'd5, 32'h0,       32'h0,         32'h0,         0,  0,  9, 0,32'h0,        0, 2); // 10 LHU
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h2,         32'h0,         0,  0,  0, 0,32'h0,        0, 2);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'hBEEF_0000, 0,  0,  0, 0,32'h0,        0, 2);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 1,32'h0000_BEEF,0, 2);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 3);
    add(0,0,1, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 3); // 15 x0
    add(0,0,1, 4, 3,3'd0, 32'h0,       32'h55,        32'h0,         0,  0,  4, 0,32'h0,        0, 3); // none
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h66,        32'h77,        0,  0,  0, 0,32'h0,        0, 3);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 3);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 3);
    add(0,0,1,12, 2,3'd0, 32'h2004,    32'h0,         32'h0,         0,  0, 12, 0,32'h0,        0, 3); // 20 PC+4
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'hDEAD,      32'h0,         0,  0,  0, 0,32'h0,        0, 3);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h1234_5678, 0,  0,  0, 0,32'h0,        0, 3);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 1,32'h2004,     0, 3);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 4);
    add(0,0,1, 3, 0,3'd0, 32'h0,       32'h0,         32'h0,         3,  0,  3, 0,32'h0,        1, 4); // 25 hazard rs1
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h7,         32'h0,         3,  0,  0, 0,32'h0,        1, 4);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         3,  0,  0, 0,32'h0,        1, 4);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         3,  0,  0, 1,32'h7,        0, 4);
    add(0,0,1, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 5);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 5); // 30
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 5);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 5);
    add(0,0,1,17, 0,3'd0, 32'h0,       32'h0,         32'h0,         0, 17, 17, 0,32'h0,        1, 5); // hazard rs2
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h11,        32'h0,         0, 17,  0, 0,32'h0,        1, 5);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0, 17,  0, 0,32'h0,        1, 5); // 35
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0, 17,  0, 1,32'h11,       0, 5);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 6);
    add(0,0,1,20, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0, 20, 0,32'h0,        0, 6); // flush seq
    add(0,0,1,21, 0,3'd0, 32'h0,       32'hA0,        32'h0,         0,  0, 21, 0,32'h0,        0, 6);
    add(0,1,1,22, 0,3'd0, 32'h0,       32'hB0,        32'h0,        21,  0,  0, 0,32'h0,        1, 6); // 40
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'hC0,        32'h0,        21, 20,  0, 1,32'hA0,       0, 6);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 7);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 7);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 7);
    add(0,0,1,20, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0, 20, 0,32'h0,        0, 7); // 45 reset seq
    add(1,0,1,21, 0,3'd0, 32'h0,       32'hA0,        32'h0,         0,  0, 21, 0,32'h0,        0, 7);
    add(0,1,1,22, 0,3'd0, 32'h0,       32'hB0,        32'h0,         0,  0,  0, 0,32'h0,        0, 0);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'hC0,        32'h0,        20, 21,  0, 0,32'h0,        0, 0);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 0);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 0); // 50
    add(0,0,1, 1, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  1, 0,32'h0,        0, 0);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'hFFFF_FFFF, 32'h0,         0,  0,  0, 0,32'h0,        0, 0);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 0);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 1,32'hFFFF_FFFF,0, 0);
    add(0,0,0, 0, 0,3'd0, 32'h0,       32'h0,         32'h0,         0,  0,  0, 0,32'h0,        0, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].iv, tbl[i].rd, tbl[i].ws, tbl[i].f3,
            tbl[i].pc4, tbl[i].alu, tbl[i].mem, tbl[i].a, tbl[i].b);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_we, tbl[i].e_data,
                 tbl[i].e_haz, tbl[i].e_cnt);
      @(posedge clk);
      #1;
    end

    // Randomized traffic; the first three cycles hold reset so earlier history is flushed.
    for (int c = 0; c < NR; c++) begin
      r_rst[c] = (c < 3) || ($urandom_range(99, 0) < 3);
      r_fl[c]  = ($urandom_range(99, 0) < 10);
      r_iv[c]  = ($urandom_range(99, 0) < 75);
      r_rw[c]  = ($urandom_range(99, 0) < 85);
      r_rd[c]  = 5'($urandom_range(7, 0));
      r_ws[c]  = 2'($urandom_range(3, 0));
      r_f3[c]  = 3'($urandom_range(7, 0));
      r_pc4[c] = $urandom;
      r_alu[c] = $urandom;
      r_mem[c] = $urandom;
      r_rs1[c] = 5'($urandom_range(7, 0));
      r_rs2[c] = 5'($urandom_range(7, 0));
    end

    model_cnt = 0;
    for (int c = 0; c < NR; c++) begin
      drive(r_rst[c], r_fl[c], r_iv[c], r_rw[c], r_rd[c], r_ws[c], r_f3[c], r_pc4[c],
            r_alu[c], r_mem[c], r_rs1[c], r_rs2[c]);
      @(negedge clk);
      if (c >= 3) begin
        e_addr = (r_iv[c] && r_rw[c] && !r_fl[c]) ? r_rd[c] : 5'd0;
        check_outs($sformatf("rnd%0d", c), e_addr, m_we(c), m_we(c) ? m_data(c) : 32'd0,
                   m_pending(c, r_rs1[c]) || m_pending(c, r_rs2[c]), 32'(model_cnt));
      end
      if (r_rst[c]) model_cnt = 0;
      else if (m_we(c)) model_cnt++;
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
